// File: rtl/program_counter_ras.sv
// Fetch-stage program counter with PC-relative branch and a circular return-address stack.
// Define PC_TRACE_EN to add the trace_valid/trace_from/trace_to ports.
module program_counter_ras #(
    parameter int ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int RAS_DEPTH  = 8,
    parameter int INC_STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              increment,
    input  logic              load,
    input  logic [ADDR_W-1:0] d_bus,
    input  logic              branch_rel,
    input  logic [ADDR_W-1:0] offset,
    input  logic              call,
    input  logic              ret,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] i_addr,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
`ifdef PC_TRACE_EN
    output logic              ras_underflow,
    output logic              trace_valid,
    output logic [ADDR_W-1:0] trace_from,
    output logic [ADDR_W-1:0] trace_to
`else
    output logic              ras_underflow
`endif
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_stack [RAS_DEPTH];
    logic [PW-1:0]     r_wp;
    logic [CW-1:0]     r_cnt;
    logic              r_ovf;
    logic              r_unf;

    logic [ADDR_W-1:0] w_seq;
    logic [PW-1:0]     w_top;
    logic              w_empty;
    logic              w_full;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [PW-1:0]     w_wp_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_push;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_nonseq;

    assign w_seq   = r_pc + ADDR_W'(INC_STEP);
    assign w_top   = r_wp - PW'(1);
    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == CW'(RAS_DEPTH));

    // Highest-priority command wins; stall freezes everything.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_wp_nxt  = r_wp;
        w_cnt_nxt = r_cnt;
        w_push    = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        w_nonseq  = 1'b0;
        if (stall) begin
            w_pc_nxt = r_pc;
        end else if (ret) begin
            w_nonseq = 1'b1;
            if (!w_empty) begin
                w_pc_nxt  = r_stack[w_top];
                w_wp_nxt  = w_top;
                w_cnt_nxt = r_cnt - CW'(1);
            end else begin
                w_pc_nxt  = w_seq;
                w_unf_set = 1'b1;
            end
        end else if (call) begin
            w_nonseq = 1'b1;
            w_push   = 1'b1;
            w_pc_nxt = d_bus;
            w_wp_nxt = r_wp + PW'(1);
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end else if (load) begin
            w_nonseq = 1'b1;
            w_pc_nxt = d_bus;
        end else if (branch_rel) begin
            w_nonseq = 1'b1;
            w_pc_nxt = r_pc + offset;
        end else if (increment) begin
            w_pc_nxt = w_seq;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= RESET_ADDR;
            r_wp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else if (!stall) begin
            r_pc  <= w_pc_nxt;
            r_wp  <= w_wp_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_set | (r_ovf & ~clr_err);
            r_unf <= w_unf_set | (r_unf & ~clr_err);
        end
    end

    // Stack contents need no reset; when full, r_wp already points at the oldest entry.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[r_wp] <= w_seq;
        end
    end

    assign i_addr        = r_pc;
    assign ras_empty     = w_empty;
    assign ras_full      = w_full;
    assign ras_overflow  = r_ovf;
    assign ras_underflow = r_unf;

`ifdef PC_TRACE_EN
    logic              r_tv;
    logic [ADDR_W-1:0] r_tfrom;
    logic [ADDR_W-1:0] r_tto;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tv    <= 1'b0;
            r_tfrom <= '0;
            r_tto   <= '0;
        end else begin
            r_tv <= w_nonseq;
            if (w_nonseq) begin
                r_tfrom <= r_pc;
                r_tto   <= w_pc_nxt;
            end
        end
    end

    assign trace_valid = r_tv;
    assign trace_from  = r_tfrom;
    assign trace_to    = r_tto;
`endif

endmodule

// File: tb/tb_program_counter_ras.sv
// Scoreboard bench for program_counter_ras: driver queues hand-computed
// expectations, a monitor pops and compares one per clock after the edge.
module tb_program_counter_ras;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        increment;
    logic        load;
    logic [15:0] d_bus;
    logic        branch_rel;
    logic [15:0] offset;
    logic        call;
    logic        ret;
    logic        clr_err;
    logic [15:0] i_addr;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_overflow;
    logic        ras_underflow;
`ifdef PC_TRACE_EN
    logic        trace_valid;
    logic [15:0] trace_from;
    logic [15:0] trace_to;
`endif

    program_counter_ras #(
        .ADDR_W(16),
        .RESET_ADDR(16'h0100),
        .RAS_DEPTH(8),
        .INC_STEP(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .increment(increment),
        .load(load),
        .d_bus(d_bus),
        .branch_rel(branch_rel),
        .offset(offset),
        .call(call),
        .ret(ret),
        .clr_err(clr_err),
        .i_addr(i_addr),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ras_overflow(ras_overflow),
`ifdef PC_TRACE_EN
        .ras_underflow(ras_underflow),
        .trace_valid(trace_valid),
        .trace_from(trace_from),
        .trace_to(trace_to)
`else
        .ras_underflow(ras_underflow)
`endif
    );

    localparam logic [6:0] ST = 7'd64;
    localparam logic [6:0] RT = 7'd32;
    localparam logic [6:0] CL = 7'd16;
    localparam logic [6:0] LD = 7'd8;
    localparam logic [6:0] BR = 7'd4;
    localparam logic [6:0] IN = 7'd2;
    localparam logic [6:0] CE = 7'd1;

    typedef struct {
        string       nm;
        logic [15:0] pc;
        logic [3:0]  fl;
        logic        tv;
        logic [15:0] tf;
        logic [15:0] tt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [6:0] c, input logic [15:0] d, input logic [15:0] off);
        stall      = c[6];
        ret        = c[5];
        call       = c[4];
        load       = c[3];
        branch_rel = c[2];
        increment  = c[1];
        clr_err    = c[0];
        d_bus      = d;
        offset     = off;
    endtask

    // fl = {empty, full, overflow, underflow}
    task automatic step(input string nm, input logic [6:0] c,
                        input logic [15:0] d, input logic [15:0] off,
                        input logic [15:0] epc, input logic [3:0] efl,
                        input logic etv, input logic [15:0] etf,
                        input logic [15:0] ett);
        exp_t e;
        @(negedge clk);
        drive(c, d, off);
        e.nm = nm;
        e.pc = epc;
        e.fl = efl;
        e.tv = etv;
        e.tf = etf;
        e.tt = ett;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.nm, ".pc"}, 32'(i_addr), 32'(e.pc));
                chk({e.nm, ".flags"},
                    32'({ras_empty, ras_full, ras_overflow, ras_underflow}),
                    32'(e.fl));
`ifdef PC_TRACE_EN
                chk({e.nm, ".tv"}, 32'(trace_valid), 32'(e.tv));
                if (e.tv) begin
                    chk({e.nm, ".tf"}, 32'(trace_from), 32'(e.tf));
                    chk({e.nm, ".tt"}, 32'(trace_to), 32'(e.tt));
                end
`endif
            end
        end
    end

    initial begin : driver
        int budget;
        rst = 1'b1;
        drive(7'd0, 16'h0, 16'h0);
        #12;
        chk("rst0.pc", 32'(i_addr), 32'h0100);
        chk("rst0.flags",
            32'({ras_empty, ras_full, ras_overflow, ras_underflow}), 32'b1000);
        @(negedge clk);
        rst = 1'b0;

        step("call0", CL, 16'h0555, 16'h0, 16'h0555, 4'b0000, 1'b1, 16'h0100, 16'h0555);
        @(posedge clk);
        #3;
        drive(7'd0, 16'h0, 16'h0);
        rst = 1'b1;
        #1;
        chk("arst.pc", 32'(i_addr), 32'h0100);
        chk("arst.flags",
            32'({ras_empty, ras_full, ras_overflow, ras_underflow}), 32'b1000);
        @(negedge clk);
        rst = 1'b0;

        step("inc1", IN, 16'h0, 16'h0, 16'h0101, 4'b1000, 1'b0, 16'h0, 16'h0);
        step("inc2", IN, 16'h0, 16'h0, 16'h0102, 4'b1000, 1'b0, 16'h0, 16'h0);
        step("inc3", IN, 16'h0, 16'h0, 16'h0103, 4'b1000, 1'b0, 16'h0, 16'h0);
        step("ld40", LD, 16'h0040, 16'h0, 16'h0040, 4'b1000, 1'b1, 16'h0103, 16'h0040);
        step("brm4", BR, 16'h0, 16'hFFFC, 16'h003C, 4'b1000, 1'b1, 16'h0040, 16'h003C);
        step("ldff", LD, 16'hFFFF, 16'h0, 16'hFFFF, 4'b1000, 1'b1, 16'h003C, 16'hFFFF);
        step("incw", IN, 16'h0, 16'h0, 16'h0000, 4'b1000, 1'b0, 16'h0, 16'h0);

        step("ld10", LD, 16'h0010, 16'h0, 16'h0010, 4'b1000, 1'b1, 16'h0000, 16'h0010);
        step("callA", CL, 16'h0200, 16'h0, 16'h0200, 4'b0000, 1'b1, 16'h0010, 16'h0200);
        step("callB", CL, 16'h0300, 16'h0, 16'h0300, 4'b0000, 1'b1, 16'h0200, 16'h0300);
        step("retB", RT, 16'h0, 16'h0, 16'h0201, 4'b0000, 1'b1, 16'h0300, 16'h0201);
        step("retA", RT, 16'h0, 16'h0, 16'h0011, 4'b1000, 1'b1, 16'h0201, 16'h0011);

        step("ld0", LD, 16'h0000, 16'h0, 16'h0000, 4'b1000, 1'b1, 16'h0011, 16'h0000);
        for (int k = 0; k < 9; k++) begin
            step($sformatf("ovcall%0d", k), CL, 16'(k + 1), 16'h0, 16'(k + 1),
                 {1'b0, k >= 7, k == 8, 1'b0}, 1'b1, 16'(k), 16'(k + 1));
        end
        for (int j = 0; j < 8; j++) begin
            step($sformatf("ovret%0d", j), RT, 16'h0, 16'h0, 16'(9 - j),
                 {j == 7, 1'b0, 1'b1, 1'b0}, 1'b1,
                 (j == 0) ? 16'd9 : 16'(10 - j), 16'(9 - j));
        end
        step("ufret", RT, 16'h0, 16'h0, 16'h0003, 4'b1011, 1'b1, 16'h0002, 16'h0003);

        step("stall", ST | CL | LD | IN | CE, 16'h0777, 16'h0, 16'h0003, 4'b1011,
             1'b0, 16'h0, 16'h0);
        step("call7", CL, 16'h0700, 16'h0, 16'h0700, 4'b0011, 1'b1, 16'h0003, 16'h0700);
        step("prio", RT | CL | LD, 16'h0999, 16'h0, 16'h0004, 4'b1011,
             1'b1, 16'h0700, 16'h0004);
        step("clr", CE, 16'h0, 16'h0, 16'h0004, 4'b1000, 1'b0, 16'h0, 16'h0);
        step("setwin", RT | CE, 16'h0, 16'h0, 16'h0005, 4'b1001, 1'b1, 16'h0004, 16'h0005);
        step("clr2", CE, 16'h0, 16'h0, 16'h0005, 4'b1000, 1'b0, 16'h0, 16'h0);

        step("trld", LD, 16'h0080, 16'h0, 16'h0080, 4'b1000, 1'b1, 16'h0005, 16'h0080);
        step("trinc", IN, 16'h0, 16'h0, 16'h0081, 4'b1000, 1'b0, 16'h0, 16'h0);
        step("brm1", BR, 16'h0, 16'hFFFF, 16'h0080, 4'b1000, 1'b1, 16'h0081, 16'h0080);

        @(negedge clk);
        drive(7'd0, 16'h0, 16'h0);
        budget = 0;
        while (q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
